// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - instruction/data arbiter in front of one single-port synchronous SRAM
//
// Purpose:
//   Shares a single-port SRAM with 1-cycle read latency between the
//   instruction-side and data-side SRAMx requesters. The data side has
//   priority. An instruction request that keeps losing is forced through
//   after MAX_WAIT lost cycles. kseg0/kseg1 virtual addresses are folded to
//   physical addresses. A one-deep owner pipeline steers each response,
//   one cycle after its grant, back to the side that issued it.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   i_req/i_wen/i_addr/i_wdata          instruction request (held until i_addr_ok)
//   i_addr_ok/i_data_ok/i_rdata         instruction accept / response
//   d_req/d_wen/d_addr/d_wdata          data request (held until d_addr_ok)
//   d_addr_ok/d_data_ok/d_rdata         data accept / response
//   sram_en/sram_wen/sram_addr/sram_wdata  SRAM command pins
//   sram_rdata                          SRAM read data, valid the cycle after sram_en
module sram_port_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [3:0]  i_wen,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic             resp_vld_q, resp_vld_d;
  logic             resp_own_q, resp_own_d;   // 0 = instruction, 1 = data
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic forced;
  logic grant_i;
  logic grant_d;

  // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) both alias physical 0.
  function automatic logic [31:0] xlate(input logic [31:0] va);
    if (va[31:30] == 2'b10) begin
      xlate = {3'b000, va[28:0]};
    end else begin
      xlate = va;
    end
  endfunction

  // Grants are suppressed while reset is high so nothing reaches the SRAM.
  always_comb begin
    forced  = i_req && (wait_cnt_q == WAIT_MAX);
    grant_d = !reset && d_req && !forced;
    grant_i = !reset && i_req && !(d_req && !forced);
  end

  always_comb begin
    i_addr_ok  = grant_i;
    d_addr_ok  = grant_d;
    sram_en    = grant_i || grant_d;
    sram_wen   = 4'b0000;
    sram_addr  = xlate(i_addr);
    sram_wdata = i_wdata;
    if (grant_d) begin
      sram_wen   = d_wen;
      sram_addr  = xlate(d_addr);
      sram_wdata = d_wdata;
    end else if (grant_i) begin
      sram_wen   = i_wen;
    end
  end

  // Responses: rdata is shared and qualified only by data_ok. Gating with
  // reset drops a response whose grant happened just before reset rose.
  always_comb begin
    i_rdata   = sram_rdata;
    d_rdata   = sram_rdata;
    i_data_ok = !reset && resp_vld_q && !resp_own_q;
    d_data_ok = !reset && resp_vld_q && resp_own_q;
  end

  always_comb begin
    resp_vld_d = grant_i || grant_d;
    resp_own_d = grant_d;
    wait_cnt_d = wait_cnt_q;
    if (!i_req || grant_i) begin
      wait_cnt_d = '0;
    end else if (grant_d && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_vld_q <= 1'b0;
      resp_own_q <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      resp_vld_q <= resp_vld_d;
      resp_own_q <= resp_own_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  localparam int G_NONE = 0;
  localparam int G_I    = 1;
  localparam int G_D    = 2;

  typedef struct {
    bit          reset;
    bit          i_req;
    bit [3:0]    i_wen;
    bit [31:0]   i_addr;
    bit [31:0]   i_wdata;
    bit          d_req;
    bit [3:0]    d_wen;
    bit [31:0]   d_addr;
    bit [31:0]   d_wdata;
    int          grant;
    bit [31:0]   exp_addr;
  } vec_t;

  typedef struct {
    int cyc;
    bit own;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [3:0]  i_wen = 4'h0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [3:0]  d_wen = 4'h0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  sb_t  sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  sram_port_arbiter #(.MAX_WAIT(3), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cyc=%0d %s actual=0x%08h expected=0x%08h", cyc, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst,
                              input bit ir, input bit [31:0] ia,
                              input bit dr, input bit [3:0] dw, input bit [31:0] da,
                              input bit [31:0] dd, input int g, input bit [31:0] ea);
    vec_t v;
    v.reset = rst; v.i_req = ir; v.i_wen = 4'h0; v.i_addr = ia; v.i_wdata = 32'h1111_0000 ^ ia;
    v.d_req = dr; v.d_wen = dw; v.d_addr = da; v.d_wdata = dd;
    v.grant = g; v.exp_addr = ea;
    return v;
  endfunction

  // One clock: drive after the edge, check mid-cycle.
  task automatic apply(input vec_t v);
    logic [31:0] rd;
    bit exp_i, exp_d;
    sb_t e;
    @(posedge clk); #1;
    cyc++;
    reset = v.reset;
    i_req = v.i_req; i_wen = v.i_wen; i_addr = v.i_addr; i_wdata = v.i_wdata;
    d_req = v.d_req; d_wen = v.d_wen; d_addr = v.d_addr; d_wdata = v.d_wdata;
    rd = $urandom;
    sram_rdata = rd;
    #4;
    chk("i_addr_ok", {31'b0, i_addr_ok}, {31'b0, v.grant == G_I});
    chk("d_addr_ok", {31'b0, d_addr_ok}, {31'b0, v.grant == G_D});
    chk("sram_en", {31'b0, sram_en}, {31'b0, v.grant != G_NONE});
    if (v.grant == G_D) begin
      chk("sram_wen", {28'b0, sram_wen}, {28'b0, v.d_wen});
      chk("sram_wdata", sram_wdata, v.d_wdata);
    end else if (v.grant == G_I) begin
      chk("sram_wen", {28'b0, sram_wen}, {28'b0, v.i_wen});
      chk("sram_wdata", sram_wdata, v.i_wdata);
    end else begin
      chk("sram_wen_idle", {28'b0, sram_wen}, 32'h0);
    end
    if (v.grant != G_NONE) chk("sram_addr", sram_addr, v.exp_addr);

    exp_i = 1'b0;
    exp_d = 1'b0;
    while (sb.size() > 0 && sb[0].cyc < cyc - 1) void'(sb.pop_front());
    if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
      e = sb.pop_front();
      if (!v.reset) begin
        if (e.own) exp_d = 1'b1;
        else exp_i = 1'b1;
      end
    end
    chk("i_data_ok", {31'b0, i_data_ok}, {31'b0, exp_i});
    chk("d_data_ok", {31'b0, d_data_ok}, {31'b0, exp_d});
    if (exp_i) chk("i_rdata", i_rdata, rd);
    if (exp_d) chk("d_rdata", d_rdata, rd);

    if (v.grant != G_NONE) begin
      e.cyc = cyc;
      e.own = (v.grant == G_D);
      sb.push_back(e);
    end
  endtask

  initial begin
    int mcnt;
    int g;
    vec_t v;

    // reset with both requests pending: nothing granted
    vecs.push_back(mk(1, 1, 32'hBFC0_0000, 1, 4'h0, 32'h8000_0000, 0, G_NONE, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, G_NONE, 0));
    // single instruction read through kseg1
    vecs.push_back(mk(0, 1, 32'hBFC0_0000, 0, 4'h0, 0, 0, G_I, 32'h1FC0_0000));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, G_NONE, 0));
    // conflict: D,D,D then forced I, then D again
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 1, 32'hBFC0_0010, 1, 4'h0, 32'h8000_0200, 0,
                        (k == 3) ? G_I : G_D, (k == 3) ? 32'h1FC0_0010 : 32'h0000_0200));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, G_NONE, 0));
    // data write via kseg0, untranslated reads
    vecs.push_back(mk(0, 0, 0, 1, 4'b0011, 32'h8000_1004, 32'hDEAD_BEEF, G_D, 32'h0000_1004));
    vecs.push_back(mk(0, 0, 0, 1, 4'h0, 32'h1FAF_0000, 0, G_D, 32'h1FAF_0000));
    vecs.push_back(mk(0, 0, 0, 1, 4'h0, 32'hC000_0010, 0, G_D, 32'hC000_0010));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, G_NONE, 0));
    // back-to-back D then I, responses routed in order
    vecs.push_back(mk(0, 0, 0, 1, 4'h0, 32'h8000_0100, 0, G_D, 32'h0000_0100));
    vecs.push_back(mk(0, 1, 32'hBFC0_0004, 0, 4'h0, 0, 0, G_I, 32'h1FC0_0004));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, G_NONE, 0));
    // reset right after a D grant kills its response
    vecs.push_back(mk(0, 0, 0, 1, 4'h0, 32'h8000_0300, 0, G_D, 32'h0000_0300));
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, G_NONE, 0));
    vecs.push_back(mk(0, 1, 32'hBFC0_0008, 0, 4'h0, 0, 0, G_I, 32'h1FC0_0008));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, G_NONE, 0));

    foreach (vecs[n]) apply(vecs[n]);

    // Build up the starvation counter, reset, then confirm it restarted at 0.
    apply(mk(0, 1, 32'hBFC0_0020, 1, 4'h0, 32'h0000_0040, 0, G_D, 32'h0000_0040));
    apply(mk(0, 1, 32'hBFC0_0020, 1, 4'h0, 32'h0000_0040, 0, G_D, 32'h0000_0040));
    apply(mk(1, 1, 32'hBFC0_0020, 1, 4'h0, 32'h0000_0040, 0, G_NONE, 0));

    // Sustained conflict checked against a bench-side starvation model.
    mcnt = 0;
    for (int k = 0; k < 12; k++) begin
      g = (mcnt == 3) ? G_I : G_D;
      v = mk(0, 1, 32'hA000_0000 + 32'(k * 4), 1, 4'(k), 32'h9000_0000 + 32'(k * 8),
             32'($urandom), g, (g == G_I) ? 32'(k * 4) : 32'h1000_0000 + 32'(k * 8));
      apply(v);
      mcnt = (g == G_I) ? 0 : ((mcnt < 3) ? mcnt + 1 : 3);
    end
    apply(mk(0, 0, 0, 0, 4'h0, 0, 0, G_NONE, 0));
    apply(mk(0, 0, 0, 0, 4'h0, 0, 0, G_NONE, 0));

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
